// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared types and constants for the video frame capture slice.
//   - cap_state_e : capture FSM states (IDLE, ACTIVE, DONE)
//   - rgb_beat_t  : one output beat (RGB data + SOF/EOL tags) at the default
//                   8-bit component width; wider builds define their own beat
//                   type of the same shape and hand it to video_fifo.
//   - CRC32_POLY / CRC32_INIT : constants for the optional frame CRC
//   - NES_W / NES_H : default PPU geometry
//   - crc32_bit() : one MSB-first CRC-32 step
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int NES_W = 256;
    localparam int NES_H = 240;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
    } rgb_beat_t;

    // Shift one data bit into a non-reflected CRC-32 register.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
        logic fb;
        fb = crc[31] ^ din;
        crc32_bit = {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/video_fifo.sv
// -----------------------------------------------------------------------------
// video_fifo
//   Synchronous show-ahead FIFO: the head entry is visible on o_data whenever
//   o_empty is low. A push while full is accepted only if a pop happens in the
//   same cycle; a pop while empty is ignored.
// Ports
//   i_clk, i_rst  clock, synchronous active-high reset (flushes the FIFO)
//   i_push,i_data write request and entry
//   o_full        no free entry
//   i_pop         consume head entry
//   o_data        head entry (valid when ~o_empty)
//   o_empty       no stored entry
// -----------------------------------------------------------------------------
module video_fifo
    import video_pkg::*;
#(
    parameter type T     = rgb_beat_t,
    parameter int  DEPTH = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // Qualify push/pop against the current occupancy; a pop frees the slot a full push needs.
    always_comb begin
        w_do_pop  = i_pop & (r_count != '0);
        w_do_push = i_push & ((r_count != (AW+1)'(DEPTH)) | w_do_pop);
    end

    // Storage array; contents need no reset because r_count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/video_frame_capture.sv
// -----------------------------------------------------------------------------
// video_frame_capture
//   Tracks PPU pixel-stream geometry, converts palette indices to RGB through
//   a writable palette and streams RGB beats out on valid/ready with SOF/EOL.
//   Optional feature macro: VIDEO_CRC_EN (CRC-32 of each completed frame on
//   o_frame_crc; when undefined o_frame_crc is tied to 0).
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_pixel, i_pixel_en    PPU pixel (low IDX_W bits used) and qualifier
//   i_frame                frame strobe, rising edge starts a frame
//   i_pal_we/addr/wdata    palette write port
//   o_rgb_valid, i_rgb_ready, o_rgb_data, o_rgb_sof, o_rgb_eol  output stream
//   o_frame_done           1-cycle pulse when a frame completes with W*H pixels
//   o_frame_cnt            completed frames (wraps)
//   o_geom_err, o_overflow sticky error flags
//   o_frame_crc            CRC of the last completed frame
// -----------------------------------------------------------------------------
module video_frame_capture
    import video_pkg::*;
#(
    parameter int IMAGE_W    = NES_W,
    parameter int IMAGE_H    = NES_H,
    parameter int IDX_W      = 6,
    parameter int COMP_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_pixel,
    input  logic                  i_pixel_en,
    input  logic                  i_frame,
    input  logic                  i_pal_we,
    input  logic [IDX_W-1:0]      i_pal_addr,
    input  logic [3*COMP_W-1:0]   i_pal_wdata,
    output logic                  o_rgb_valid,
    input  logic                  i_rgb_ready,
    output logic [3*COMP_W-1:0]   o_rgb_data,
    output logic                  o_rgb_sof,
    output logic                  o_rgb_eol,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_cnt,
    output logic                  o_geom_err,
    output logic                  o_overflow,
    output logic [31:0]           o_frame_crc
);

    localparam int DATA_W = 3 * COMP_W;
    localparam int XW     = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam int YW     = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;

    // Same shape as rgb_beat_t, sized for this instance's component width.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
    } beat_t;

    logic                r_frame;
    logic                r_new_frame;
    cap_state_e          r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;
    logic                r_geom_err;
    logic                r_overflow;

    logic [DATA_W-1:0]   r_pal [2**IDX_W];
    logic                r_lut_valid;
    logic [DATA_W-1:0]   r_lut_data;
    logic                r_lut_sof;
    logic                r_lut_eol;

    logic [XW-1:0]       w_x_cur;
    logic [YW-1:0]       w_y_cur;
    logic                w_accept;
    logic                w_sof;
    logic                w_eol;
    logic                w_last;

    beat_t               w_push_beat;
    beat_t               w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_drop;
    logic                w_push_ok;

    generate
        if (IDX_W < 8) begin : g_pixel_unused
            logic w_unused_pixel_bits;
            assign w_unused_pixel_bits = ^i_pixel[7:IDX_W];
        end
    endgenerate

    // Frame strobe edge detector; r_new_frame is a registered 1-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame     <= 1'b0;
            r_new_frame <= 1'b0;
        end else begin
            r_frame     <= i_frame;
            r_new_frame <= i_frame & ~r_frame;
        end
    end

    // Current pixel position: a new frame restarts at (0,0) in the same cycle,
    // so a pixel coincident with the new-frame pulse is pixel (0,0).
    always_comb begin
        if (r_new_frame) begin
            w_x_cur = '0;
            w_y_cur = '0;
        end else begin
            w_x_cur = r_x;
            w_y_cur = r_y;
        end
        w_accept = i_pixel_en & (r_new_frame | (r_state == ACTIVE));
        w_sof    = (w_x_cur == '0) & (w_y_cur == '0);
        w_eol    = (w_x_cur == XW'(IMAGE_W - 1));
        w_last   = w_eol & (w_y_cur == YW'(IMAGE_H - 1));
    end

    // Capture FSM, geometry counters, frame completion and geometry error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_geom_err   <= 1'b0;
        end else begin
            r_frame_done <= w_accept & w_last;
            // A restart before the last pixel means the previous frame was short.
            if (r_new_frame && (r_state == ACTIVE)) begin
                r_geom_err <= 1'b1;
            end
            // Pixels after a complete frame and before the next strobe are extras.
            if (i_pixel_en && !r_new_frame && (r_state == DONE)) begin
                r_geom_err <= 1'b1;
            end
            if (w_accept) begin
                if (w_last) begin
                    r_state     <= DONE;
                    r_x         <= '0;
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else if (w_eol) begin
                    r_state <= ACTIVE;
                    r_x     <= '0;
                    r_y     <= w_y_cur + YW'(1);
                end else begin
                    r_state <= ACTIVE;
                    r_x     <= w_x_cur + XW'(1);
                    r_y     <= w_y_cur;
                end
            end else if (r_new_frame) begin
                r_state <= ACTIVE;
                r_x     <= '0;
                r_y     <= '0;
            end
        end
    end

    // Palette write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_pal_we) begin
            r_pal[i_pal_addr] <= i_pal_wdata;
        end
    end

    // Registered palette read with tags; a same-cycle write to the same entry is seen next cycle.
    always_ff @(posedge i_clk) begin
        r_lut_data <= r_pal[i_pixel[IDX_W-1:0]];
        r_lut_sof  <= w_sof;
        r_lut_eol  <= w_eol;
    end

    // Lookup-stage valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lut_valid <= 1'b0;
        end else begin
            r_lut_valid <= w_accept;
        end
    end

    // Push/pop decisions; a lookup result that finds the FIFO full with no pop is dropped.
    always_comb begin
        w_push_beat.data = r_lut_data;
        w_push_beat.sof  = r_lut_sof;
        w_push_beat.eol  = r_lut_eol;
        w_pop            = i_rgb_ready & ~w_empty;
        w_drop           = r_lut_valid & w_full & ~w_pop;
        w_push_ok        = r_lut_valid & ~w_drop;
    end

    video_fifo #(
        .T     (beat_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_lut_valid),
        .i_data  (w_push_beat),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty)
    );

    // Sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Stream outputs; the head entry is masked when empty so the bus reads 0 out of reset.
    always_comb begin
        o_rgb_valid = ~w_empty;
        if (w_empty) begin
            o_rgb_data = '0;
            o_rgb_sof  = 1'b0;
            o_rgb_eol  = 1'b0;
        end else begin
            o_rgb_data = w_head.data;
            o_rgb_sof  = w_head.sof;
            o_rgb_eol  = w_head.eol;
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_geom_err   = r_geom_err;
    assign o_overflow   = r_overflow;

`ifdef VIDEO_CRC_EN
    logic [31:0] r_crc;
    logic [31:0] r_frame_crc;
    logic [31:0] w_crc_next;

    // CRC over every beat actually written to the FIFO, MSB first.
    always_comb begin
        w_crc_next = r_crc;
        if (w_push_ok) begin
            for (int i = DATA_W - 1; i >= 0; i--) begin
                w_crc_next = crc32_bit(w_crc_next, r_lut_data[i]);
            end
        end else begin
            w_crc_next = r_crc;
        end
    end

    // The last beat of a frame is written in the frame_done cycle, so latch the updated value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_crc       <= CRC32_INIT;
            r_frame_crc <= 32'h0000_0000;
        end else begin
            if (r_new_frame) begin
                r_crc <= CRC32_INIT;
            end else begin
                r_crc <= w_crc_next;
            end
            if (r_frame_done) begin
                r_frame_crc <= ~w_crc_next;
            end
        end
    end

    assign o_frame_crc = r_frame_crc;
`else
    assign o_frame_crc = 32'h0000_0000;
`endif

endmodule
